// File: rtl/led_seq_pkg.sv
// Shared mode and direction encodings for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL     = 2'd0,
        MODE_ROTR     = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_BAR      = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/led_pattern_seq_tick_gen.sv
// Clock-enable prescaler: oTICK is a combinational strobe on the enabled cycle whose edge wraps the count.
// iEN low freezes the count; iCLR restarts it from zero and suppresses the strobe.
module tick_gen #(
    parameter int DIV   = 4,
    parameter int CNT_W = 2
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEN,
    input  logic iCLR,
    output logic oTICK
);

    logic [CNT_W-1:0] cnt;
    logic             wrap;

    assign wrap  = (cnt == CNT_W'(DIV - 1));
    assign oTICK = iEN && !iCLR && wrap;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt <= '0;
        end else if (iCLR) begin
            cnt <= '0;
        end else if (iEN) begin
            cnt <= wrap ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_seq.sv
// WIDTH-bit LED animator with four patterns; one step per DIV enabled cycles, oTICK marks each new value.
// A mode change restarts the pattern at LSB and wins over a coincident step.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 524288
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iEN,
    input  logic [1:0]       iMODE,
    output logic [WIDTH-1:0] oLED,
    output logic             oTICK
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] LED_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    if (WIDTH < 2) begin : g_width_chk
        $error("led_pattern_seq: WIDTH must be >= 2");
    end
    if (DIV < 1) begin : g_div_chk
        $error("led_pattern_seq: DIV must be >= 1");
    end

    mode_t            mode_q;
    dir_t             dir;
    dir_t             dir_step;
    logic [WIDTH-1:0] led_step;
    logic             mode_chg;
    logic             step;
    logic             legal;
    logic             go_up;

    assign mode_chg = (iMODE != mode_q);

    tick_gen #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_tick_gen (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (iEN),
        .iCLR  (mode_chg),
        .oTICK (step)
    );

    // mode_q tracks the switches even while frozen so a change is always seen.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mode_q <= mode_t'(iMODE);
        end else begin
            mode_q <= mode_t'(iMODE);
        end
    end

    always_comb begin
        led_step = oLED;
        dir_step = dir;
        legal    = 1'b1;
        go_up    = 1'b1;
        case (mode_q)
            MODE_ROTL: begin
                legal    = (oLED != '0) && ((oLED & (oLED - LED_ONE)) == '0);
                led_step = {oLED[WIDTH-2:0], oLED[WIDTH-1]};
            end
            MODE_ROTR: begin
                legal    = (oLED != '0) && ((oLED & (oLED - LED_ONE)) == '0);
                led_step = {oLED[0], oLED[WIDTH-1:1]};
            end
            MODE_PINGPONG: begin
                legal    = (oLED != '0) && ((oLED & (oLED - LED_ONE)) == '0);
                go_up    = (dir == DIR_UP) ? !oLED[WIDTH-1] : oLED[0];
                led_step = go_up ? {oLED[WIDTH-2:0], 1'b0} : {1'b0, oLED[WIDTH-1:1]};
                dir_step = led_step[WIDTH-1] ? DIR_DOWN :
                           led_step[0]       ? DIR_UP   :
                           go_up             ? DIR_UP   : DIR_DOWN;
            end
            MODE_BAR: begin
                legal    = (oLED != '0) && ((oLED & (oLED + LED_ONE)) == '0);
                go_up    = (dir == DIR_UP) ? !(&oLED) : (oLED == LED_ONE);
                led_step = go_up ? {oLED[WIDTH-2:0], 1'b1} : {1'b0, oLED[WIDTH-1:1]};
                dir_step = (&led_step)           ? DIR_DOWN :
                           (led_step == LED_ONE) ? DIR_UP   :
                           go_up                 ? DIR_UP   : DIR_DOWN;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
        // An illegal pattern (e.g. upset) is repaired at the next step rather than animated.
        if (!legal) begin
            led_step = LED_ONE;
            dir_step = DIR_UP;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oLED  <= LED_ONE;
            dir   <= DIR_UP;
            oTICK <= 1'b0;
        end else if (mode_chg) begin
            oLED  <= LED_ONE;
            dir   <= DIR_UP;
            oTICK <= 1'b0;
        end else begin
            oTICK <= step;
            if (step) begin
                oLED <= led_step;
                dir  <= dir_step;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq at WIDTH=8, DIV=4; outputs sampled on the falling edge.
module tb_led_pattern_seq;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] led;
    logic       tick;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] t_rotl [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01,
                                8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] t_ping [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h00};
    logic [7:0] t_bar  [16] = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h7F,
                                8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h03, 8'h00};

    led_pattern_seq #(
        .WIDTH (8),
        .DIV   (4)
    ) dut (
        .iCLK  (clk),
        .iRST  (rst),
        .iEN   (en),
        .iMODE (mode),
        .oLED  (led),
        .oTICK (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // n steps of the pattern: three hold cycles with tick low, then the new value with tick high.
    task automatic expect_steps(input string tag, input int n, input logic [7:0] tbl [16],
                                input logic [7:0] start);
        logic [7:0] prev;
        prev = start;
        for (int s = 0; s < n; s++) begin
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk({tag, "_hold_led"}, 32'(led), 32'(prev));
                chk({tag, "_hold_tick"}, 32'(tick), 32'd0);
            end
            @(negedge clk);
            chk({tag, "_step_led"}, 32'(led), 32'(tbl[s]));
            chk({tag, "_step_tick"}, 32'(tick), 32'd1);
            prev = tbl[s];
        end
    endtask

    task automatic change_mode(input string tag, input logic [1:0] m);
        mode = m;
        @(negedge clk);
        chk({tag, "_led"}, 32'(led), 32'h01);
        chk({tag, "_tick"}, 32'(tick), 32'd0);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        mode = 2'd0;
        repeat (2) @(negedge clk);
        chk("reset_led", 32'(led), 32'h01);
        chk("reset_tick", 32'(tick), 32'd0);
        rst = 1'b0;

        // 1: ROTL for 40 cycles
        expect_steps("rotl", 10, t_rotl, 8'h01);

        // 2: PINGPONG for 60 cycles, no repeated ends
        change_mode("to_ping", 2'd2);
        expect_steps("ping", 15, t_ping, 8'h01);

        // 3: BAR for 60 cycles
        change_mode("to_bar", 2'd3);
        expect_steps("bar", 15, t_bar, 8'h01);

        // 4: freeze at 08 with one prescaler count already consumed
        change_mode("to_rotl", 2'd0);
        expect_steps("rotl2", 3, t_rotl, 8'h01);
        @(negedge clk);
        chk("pre_freeze_led", 32'(led), 32'h08);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("frozen_led", 32'(led), 32'h08);
            chk("frozen_tick", 32'(tick), 32'd0);
        end
        en = 1'b1;
        repeat (2) @(negedge clk);
        chk("resume_hold_led", 32'(led), 32'h08);
        chk("resume_hold_tick", 32'(tick), 32'd0);
        @(negedge clk);
        chk("resume_step_led", 32'(led), 32'h10);
        chk("resume_step_tick", 32'(tick), 32'd1);

        // 5: mode change coinciding with a due step
        change_mode("to_ping2", 2'd2);
        expect_steps("ping2", 5, t_ping, 8'h01);
        repeat (3) @(negedge clk);
        chk("due_led", 32'(led), 32'h20);
        change_mode("chg_over_step", 2'd1);
        repeat (3) @(negedge clk);
        chk("rotr_hold_led", 32'(led), 32'h01);
        @(negedge clk);
        chk("rotr_first_led", 32'(led), 32'h80);
        chk("rotr_first_tick", 32'(tick), 32'd1);

        // 6: asynchronous reset between edges while showing 40
        repeat (4) @(negedge clk);
        chk("pre_rst_led", 32'(led), 32'h40);
        chk("pre_rst_tick", 32'(tick), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_led", 32'(led), 32'h01);
        chk("async_rst_tick", 32'(tick), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_hold_led", 32'(led), 32'h01);
        chk("post_rst_hold_tick", 32'(tick), 32'd0);
        @(negedge clk);
        chk("post_rst_step_led", 32'(led), 32'h80);
        chk("post_rst_step_tick", 32'(tick), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
